// File: rtl/ysyx_25030093_axi_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter: one granted master owns the slave for a whole
// AR->R or AW+W->B transaction; fixed-priority or round-robin selection.
//
// state   | meaning
// IDLE    | no owner; pick a winner from pending requests
// RD_ADDR | forward AR of granted master until slave accepts
// RD_DATA | forward R back to granted master until it accepts
// WR_REQ  | forward AW and W independently until both handshaken
// WR_RESP | forward B back to granted master until it accepts
module ysyx_25030093_axi_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STRB_W      = 8,
  parameter int RR_MODE     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_arvalid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
  output logic [NUM_MASTERS-1:0]        m_arready,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  input  logic [NUM_MASTERS-1:0]        m_rready,
  output logic [DATA_W-1:0]             m_rdata,
  input  logic [NUM_MASTERS-1:0]        m_awvalid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr,
  output logic [NUM_MASTERS-1:0]        m_awready,
  input  logic [NUM_MASTERS-1:0]        m_wvalid,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb,
  output logic [NUM_MASTERS-1:0]        m_wready,
  output logic [NUM_MASTERS-1:0]        m_bvalid,
  input  logic [NUM_MASTERS-1:0]        m_bready,
  output logic                          s_arvalid,
  output logic [ADDR_W-1:0]             s_araddr,
  input  logic                          s_arready,
  input  logic                          s_rvalid,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic                          s_rready,
  output logic                          s_awvalid,
  output logic [ADDR_W-1:0]             s_awaddr,
  input  logic                          s_awready,
  output logic                          s_wvalid,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [STRB_W-1:0]             s_wstrb,
  input  logic                          s_wready,
  input  logic                          s_bvalid,
  output logic                          s_bready,
  output logic [NUM_MASTERS-1:0]        grant_oh
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       gidx_q;
  logic [IDX_W-1:0]       ptr_q;
  logic                   aw_done_q;
  logic                   w_done_q;

  logic [NUM_MASTERS-1:0] req;
  logic [IDX_W-1:0]       win_d;
  logic                   found_d;
  int                     cand;
  logic [IDX_W-1:0]       ptr_d;
  logic                   ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign req = m_arvalid | m_awvalid;

  // Scan from the pointer (RR) or from index 0 (fixed); first pending request wins.
  always_comb begin
    win_d   = '0;
    found_d = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = (RR_MODE != 0) ? ((int'(ptr_q) + k) % NUM_MASTERS) : k;
      if (!found_d && req[cand]) begin
        found_d = 1'b1;
        win_d   = IDX_W'(cand);
      end
    end
  end

  assign ptr_d = (gidx_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : gidx_q + IDX_W'(1);

  assign s_araddr = m_araddr[gidx_q*ADDR_W +: ADDR_W];
  assign s_awaddr = m_awaddr[gidx_q*ADDR_W +: ADDR_W];
  assign s_wdata  = m_wdata[gidx_q*DATA_W +: DATA_W];
  assign s_wstrb  = m_wstrb[gidx_q*STRB_W +: STRB_W];
  assign m_rdata  = s_rdata;
  assign grant_oh = grant_q;

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    case (state_q)
      RD_ADDR: begin
        s_arvalid         = m_arvalid[gidx_q];
        m_arready[gidx_q] = s_arready;
      end
      RD_DATA: begin
        m_rvalid[gidx_q] = s_rvalid;
        s_rready         = m_rready[gidx_q];
      end
      WR_REQ: begin
        // Once a channel has handshaken it stays quiet until the response phase.
        s_awvalid         = m_awvalid[gidx_q] & ~aw_done_q;
        m_awready[gidx_q] = s_awready & ~aw_done_q;
        s_wvalid          = m_wvalid[gidx_q] & ~w_done_q;
        m_wready[gidx_q]  = s_wready & ~w_done_q;
      end
      WR_RESP: begin
        m_bvalid[gidx_q] = s_bvalid;
        s_bready         = m_bready[gidx_q];
      end
      default: ;
    endcase
  end

  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid & s_rready;
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bvalid & s_bready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            gidx_q  <= win_d;
            grant_q <= NUM_MASTERS'(1) << win_d;
            state_q <= m_arvalid[win_d] ? RD_ADDR : WR_REQ;
          end
        end
        RD_ADDR: begin
          if (ar_hs) state_q <= RD_DATA;
        end
        RD_DATA: begin
          if (r_hs) begin
            state_q <= IDLE;
            grant_q <= '0;
            if (RR_MODE != 0) ptr_q <= ptr_d;
          end
        end
        WR_REQ: begin
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
            state_q   <= WR_RESP;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            state_q <= IDLE;
            grant_q <= '0;
            if (RR_MODE != 0) ptr_q <= ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_axi_arbiter.sv
// Directed bench: a 2-master fixed-priority arbiter and a 4-master round-robin arbiter,
// with scoreboards for read data, write beats and round-robin grant order.
module tb_ysyx_25030093_axi_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // DUT A: 2 masters, fixed priority
  logic [1:0]  a_m_arvalid, a_m_arready, a_m_rvalid, a_m_rready;
  logic [63:0] a_m_araddr, a_m_awaddr, a_m_wdata;
  logic [31:0] a_m_rdata;
  logic [1:0]  a_m_awvalid, a_m_awready, a_m_wvalid, a_m_wready, a_m_bvalid, a_m_bready;
  logic [15:0] a_m_wstrb;
  logic        a_s_arvalid, a_s_arready, a_s_rvalid, a_s_rready;
  logic [31:0] a_s_araddr, a_s_rdata, a_s_awaddr, a_s_wdata;
  logic        a_s_awvalid, a_s_awready, a_s_wvalid, a_s_wready, a_s_bvalid, a_s_bready;
  logic [7:0]  a_s_wstrb;
  logic [1:0]  a_grant_oh;

  // DUT B: 4 masters, round robin
  logic [3:0]   b_m_arvalid, b_m_arready, b_m_rvalid, b_m_rready;
  logic [127:0] b_m_araddr, b_m_awaddr, b_m_wdata;
  logic [31:0]  b_m_rdata;
  logic [3:0]   b_m_awvalid, b_m_awready, b_m_wvalid, b_m_wready, b_m_bvalid, b_m_bready;
  logic [31:0]  b_m_wstrb;
  logic         b_s_arvalid, b_s_arready, b_s_rvalid, b_s_rready;
  logic [31:0]  b_s_araddr, b_s_rdata, b_s_awaddr, b_s_wdata;
  logic         b_s_awvalid, b_s_awready, b_s_wvalid, b_s_wready, b_s_bvalid, b_s_bready;
  logic [7:0]   b_s_wstrb;
  logic [3:0]   b_grant_oh;

  ysyx_25030093_axi_arbiter #(.NUM_MASTERS(2), .RR_MODE(0)) dut_a (
    .clk(clk), .rst(rst),
    .m_arvalid(a_m_arvalid), .m_araddr(a_m_araddr), .m_arready(a_m_arready),
    .m_rvalid(a_m_rvalid), .m_rready(a_m_rready), .m_rdata(a_m_rdata),
    .m_awvalid(a_m_awvalid), .m_awaddr(a_m_awaddr), .m_awready(a_m_awready),
    .m_wvalid(a_m_wvalid), .m_wdata(a_m_wdata), .m_wstrb(a_m_wstrb), .m_wready(a_m_wready),
    .m_bvalid(a_m_bvalid), .m_bready(a_m_bready),
    .s_arvalid(a_s_arvalid), .s_araddr(a_s_araddr), .s_arready(a_s_arready),
    .s_rvalid(a_s_rvalid), .s_rdata(a_s_rdata), .s_rready(a_s_rready),
    .s_awvalid(a_s_awvalid), .s_awaddr(a_s_awaddr), .s_awready(a_s_awready),
    .s_wvalid(a_s_wvalid), .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb), .s_wready(a_s_wready),
    .s_bvalid(a_s_bvalid), .s_bready(a_s_bready),
    .grant_oh(a_grant_oh)
  );

  ysyx_25030093_axi_arbiter #(.NUM_MASTERS(4), .RR_MODE(1)) dut_b (
    .clk(clk), .rst(rst),
    .m_arvalid(b_m_arvalid), .m_araddr(b_m_araddr), .m_arready(b_m_arready),
    .m_rvalid(b_m_rvalid), .m_rready(b_m_rready), .m_rdata(b_m_rdata),
    .m_awvalid(b_m_awvalid), .m_awaddr(b_m_awaddr), .m_awready(b_m_awready),
    .m_wvalid(b_m_wvalid), .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb), .m_wready(b_m_wready),
    .m_bvalid(b_m_bvalid), .m_bready(b_m_bready),
    .s_arvalid(b_s_arvalid), .s_araddr(b_s_araddr), .s_arready(b_s_arready),
    .s_rvalid(b_s_rvalid), .s_rdata(b_s_rdata), .s_rready(b_s_rready),
    .s_awvalid(b_s_awvalid), .s_awaddr(b_s_awaddr), .s_awready(b_s_awready),
    .s_wvalid(b_s_wvalid), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_wready(b_s_wready),
    .s_bvalid(b_s_bvalid), .s_bready(b_s_bready),
    .grant_oh(b_grant_oh)
  );

  logic [63:0] rd_q[$];
  logic [63:0] wr_q[$];
  logic [63:0] gr_q[$];
  logic [63:0] rd_e, wr_e, gr_e;
  logic [3:0]  b_prev = 4'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Read-data scoreboard on DUT A: {granted one-hot, rdata}
  always @(negedge clk) begin
    if (rst && ((a_m_rvalid & a_m_rready) != 2'b00)) begin
      chk("rd_sb_pending", 64'(rd_q.size() != 0), 64'd1);
      if (rd_q.size() != 0) begin
        rd_e = rd_q.pop_front();
        chk("rd_sb_data", {30'd0, a_m_rvalid, a_m_rdata}, rd_e);
      end
    end
  end

  // Write-beat scoreboard on DUT A slave side: {wstrb, wdata}
  always @(negedge clk) begin
    if (rst && a_s_wvalid && a_s_wready) begin
      chk("wr_sb_pending", 64'(wr_q.size() != 0), 64'd1);
      if (wr_q.size() != 0) begin
        wr_e = wr_q.pop_front();
        chk("wr_sb_beat", {24'd0, a_s_wstrb, a_s_wdata}, wr_e);
      end
    end
  end

  // Grant-order scoreboard on DUT B: {grant one-hot, forwarded araddr} on each new grant
  always @(negedge clk) begin
    if (rst && b_grant_oh != 4'd0 && b_prev == 4'd0) begin
      chk("rr_sb_pending", 64'(gr_q.size() != 0), 64'd1);
      if (gr_q.size() != 0) begin
        gr_e = gr_q.pop_front();
        chk("rr_grant", {28'd0, b_grant_oh, b_s_araddr}, gr_e);
        chk("rr_arready", 64'(b_m_arready), 64'(gr_e[35:32]));
      end
    end
    b_prev = b_grant_oh;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    a_m_arvalid = '0; a_m_araddr = '0; a_m_rready = '0; a_m_awvalid = '0; a_m_awaddr = '0;
    a_m_wvalid = '0; a_m_wdata = '0; a_m_wstrb = '0; a_m_bready = '0;
    a_s_arready = 1'b0; a_s_rvalid = 1'b0; a_s_rdata = '0; a_s_awready = 1'b0;
    a_s_wready = 1'b0; a_s_bvalid = 1'b0;
    b_m_arvalid = '0; b_m_rready = 4'hF; b_m_awvalid = '0; b_m_awaddr = '0;
    b_m_wvalid = '0; b_m_wdata = '0; b_m_wstrb = '0; b_m_bready = 4'hF;
    b_m_araddr = {32'h1000_0030, 32'h1000_0020, 32'h1000_0010, 32'h1000_0000};
    b_s_arready = 1'b1; b_s_rvalid = 1'b1; b_s_rdata = 32'h5A5A_0001;
    b_s_awready = 1'b0; b_s_wready = 1'b0; b_s_bvalid = 1'b0;

    nx(); nx();
    smp();
    chk("rst_grant_a", 64'(a_grant_oh), 64'd0);
    chk("rst_grant_b", 64'(b_grant_oh), 64'd0);
    chk("rst_handshakes_a", 64'({a_m_arready, a_m_rvalid, a_m_awready, a_m_wready, a_m_bvalid,
        a_s_arvalid, a_s_rready, a_s_awvalid, a_s_wvalid, a_s_bready}), 64'd0);
    nx(); rst = 1'b1;
    smp();

    // Single read by master 1, 0-wait slave
    nx();
    a_m_araddr[32 +: 32] = 32'h8000_0004; a_m_arvalid = 2'b10; a_m_rready = 2'b11;
    a_s_arready = 1'b1; a_s_rvalid = 1'b1; a_s_rdata = 32'hDEAD_BEEF;
    rd_q.push_back({30'd0, 2'b10, 32'hDEAD_BEEF});
    smp(); chk("rd1_idle_arvalid", 64'(a_s_arvalid), 64'd0);
    nx(); smp();
    chk("rd1_s_arvalid", 64'(a_s_arvalid), 64'd1);
    chk("rd1_araddr", 64'(a_s_araddr), 64'h8000_0004);
    chk("rd1_grant", 64'(a_grant_oh), 64'd2);
    chk("rd1_arready", 64'(a_m_arready), 64'd2);
    nx(); a_m_arvalid = 2'b00;
    smp(); chk("rd1_rvalid", 64'(a_m_rvalid), 64'd2);
    nx(); smp();
    chk("rd1_grant_clr", 64'(a_grant_oh), 64'd0);
    chk("rd1_rvalid_idle", 64'(a_m_rvalid), 64'd0);

    // Simultaneous reads, fixed priority: master 0 first, one IDLE gap, then master 1
    nx();
    a_m_araddr = {32'h0000_0200, 32'h0000_0100}; a_m_arvalid = 2'b11; a_s_rdata = 32'h1111_0000;
    rd_q.push_back({30'd0, 2'b01, 32'h1111_0000});
    rd_q.push_back({30'd0, 2'b10, 32'h2222_0000});
    smp(); chk("rd2_idle_arvalid", 64'(a_s_arvalid), 64'd0);
    nx(); smp();
    chk("rd2_grant_m0", 64'(a_grant_oh), 64'd1);
    chk("rd2_araddr_m0", 64'(a_s_araddr), 64'h100);
    chk("rd2_arready_m0", 64'(a_m_arready), 64'd1);
    nx(); a_m_arvalid = 2'b10;
    smp(); chk("rd2_rvalid_m0", 64'(a_m_rvalid), 64'd1);
    nx(); a_s_rdata = 32'h2222_0000;
    smp();
    chk("rd2_gap_arvalid", 64'(a_s_arvalid), 64'd0);
    chk("rd2_gap_grant", 64'(a_grant_oh), 64'd0);
    nx(); smp();
    chk("rd2_s_arvalid_m1", 64'(a_s_arvalid), 64'd1);
    chk("rd2_grant_m1", 64'(a_grant_oh), 64'd2);
    chk("rd2_araddr_m1", 64'(a_s_araddr), 64'h200);
    nx(); a_m_arvalid = 2'b00;
    smp(); chk("rd2_rvalid_m1", 64'(a_m_rvalid), 64'd2);
    nx(); smp(); chk("rd2_grant_clr", 64'(a_grant_oh), 64'd0);

    // Write by master 1 with AW accepted in cycle 1 and W in cycle 3
    nx();
    a_s_arready = 1'b0;
    a_m_awaddr[32 +: 32] = 32'h8000_1000; a_m_wdata[32 +: 32] = 32'h1234_5678;
    a_m_wstrb[8 +: 8] = 8'h0F; a_m_awvalid = 2'b10; a_m_wvalid = 2'b10; a_m_bready = 2'b11;
    wr_q.push_back({24'd0, 8'h0F, 32'h1234_5678});
    smp(); chk("wr1_idle_awvalid", 64'(a_s_awvalid), 64'd0);
    nx(); a_s_awready = 1'b1;
    smp();
    chk("wr1_c1_awvalid", 64'(a_s_awvalid), 64'd1);
    chk("wr1_c1_awaddr", 64'(a_s_awaddr), 64'h8000_1000);
    chk("wr1_c1_wvalid", 64'(a_s_wvalid), 64'd1);
    chk("wr1_c1_awready", 64'(a_m_awready), 64'd2);
    chk("wr1_c1_wready", 64'(a_m_wready), 64'd0);
    nx(); smp();
    chk("wr1_c2_aw_masked", 64'(a_s_awvalid), 64'd0);
    chk("wr1_c2_awready_masked", 64'(a_m_awready), 64'd0);
    chk("wr1_c2_wvalid", 64'(a_s_wvalid), 64'd1);
    nx(); a_s_wready = 1'b1;
    smp(); chk("wr1_c3_wready", 64'(a_m_wready), 64'd2);
    nx(); a_m_awvalid = 2'b00; a_m_wvalid = 2'b00; a_s_wready = 1'b0; a_s_awready = 1'b0;
    smp();
    chk("wr1_resp_bvalid_low", 64'(a_m_bvalid), 64'd0);
    chk("wr1_resp_bready", 64'(a_s_bready), 64'd1);
    chk("wr1_resp_wvalid", 64'(a_s_wvalid), 64'd0);
    nx(); a_s_bvalid = 1'b1;
    smp(); chk("wr1_resp_bvalid", 64'(a_m_bvalid), 64'd2);
    nx(); a_s_bvalid = 1'b0;
    smp();
    chk("wr1_grant_clr", 64'(a_grant_oh), 64'd0);
    chk("wr1_bvalid_idle", 64'(a_m_bvalid), 64'd0);

    // Reset in the middle of RD_DATA, then a fresh read
    nx();
    a_m_araddr[0 +: 32] = 32'h0000_0300; a_m_arvalid = 2'b01; a_s_arready = 1'b1; a_s_rvalid = 1'b0;
    smp();
    nx(); smp(); chk("rst_rd_grant", 64'(a_grant_oh), 64'd1);
    nx(); a_m_arvalid = 2'b00;
    smp();
    chk("rst_rd_data_grant", 64'(a_grant_oh), 64'd1);
    chk("rst_rd_data_rready", 64'(a_s_rready), 64'd1);
    nx(); rst = 1'b0;
    smp();
    nx(); rst = 1'b1; a_s_rvalid = 1'b1; a_s_rdata = 32'hCAFE_F00D;
    smp();
    chk("rst_mid_grant", 64'(a_grant_oh), 64'd0);
    chk("rst_mid_master_hs", 64'({a_m_arready, a_m_rvalid, a_m_awready, a_m_wready, a_m_bvalid}), 64'd0);
    chk("rst_mid_rready", 64'(a_s_rready), 64'd0);
    nx();
    a_m_araddr[0 +: 32] = 32'h0000_0304; a_m_arvalid = 2'b01;
    rd_q.push_back({30'd0, 2'b01, 32'hCAFE_F00D});
    smp();
    nx(); smp();
    chk("rst_fresh_arvalid", 64'(a_s_arvalid), 64'd1);
    chk("rst_fresh_araddr", 64'(a_s_araddr), 64'h304);
    nx(); a_m_arvalid = 2'b00;
    smp(); chk("rst_fresh_rvalid", 64'(a_m_rvalid), 64'd1);
    nx(); smp(); chk("rst_fresh_grant_clr", 64'(a_grant_oh), 64'd0);

    // Master 0 raises read and write together: read first, one IDLE, then write
    nx();
    a_m_araddr[0 +: 32] = 32'h0000_0400; a_m_awaddr[0 +: 32] = 32'h0000_0500;
    a_m_wdata[0 +: 32] = 32'hAABB_CCDD; a_m_wstrb[0 +: 8] = 8'h03;
    a_m_arvalid = 2'b01; a_m_awvalid = 2'b01; a_m_wvalid = 2'b01;
    a_s_arready = 1'b1; a_s_rvalid = 1'b1; a_s_rdata = 32'h0BAD_CAFE;
    a_s_awready = 1'b1; a_s_wready = 1'b1; a_s_bvalid = 1'b1;
    rd_q.push_back({30'd0, 2'b01, 32'h0BAD_CAFE});
    wr_q.push_back({24'd0, 8'h03, 32'hAABB_CCDD});
    smp();
    nx(); smp();
    chk("rw_read_first", 64'(a_s_arvalid), 64'd1);
    chk("rw_aw_held", 64'({a_s_awvalid, a_s_wvalid}), 64'd0);
    chk("rw_grant_rd", 64'(a_grant_oh), 64'd1);
    nx(); a_m_arvalid = 2'b00;
    smp(); chk("rw_rvalid", 64'(a_m_rvalid), 64'd1);
    nx(); smp();
    chk("rw_gap_grant", 64'(a_grant_oh), 64'd0);
    chk("rw_gap_awvalid", 64'(a_s_awvalid), 64'd0);
    nx(); smp();
    chk("rw_awvalid", 64'(a_s_awvalid), 64'd1);
    chk("rw_awaddr", 64'(a_s_awaddr), 64'h500);
    chk("rw_grant_wr", 64'(a_grant_oh), 64'd1);
    nx(); a_m_awvalid = 2'b00; a_m_wvalid = 2'b00;
    smp(); chk("rw_bvalid", 64'(a_m_bvalid), 64'd1);
    nx(); a_s_bvalid = 1'b0; a_s_awready = 1'b0; a_s_wready = 1'b0;
    smp(); chk("rw_grant_clr", 64'(a_grant_oh), 64'd0);

    // Round robin on DUT B: four masters requesting continuously
    nx();
    gr_q.push_back({28'd0, 4'b0001, 32'h1000_0000});
    gr_q.push_back({28'd0, 4'b0010, 32'h1000_0010});
    gr_q.push_back({28'd0, 4'b0100, 32'h1000_0020});
    gr_q.push_back({28'd0, 4'b1000, 32'h1000_0030});
    gr_q.push_back({28'd0, 4'b0001, 32'h1000_0000});
    b_m_arvalid = 4'hF;
    repeat (14) nx();
    b_m_arvalid = 4'h0;
    repeat (4) nx();
    smp();
    chk("rr_grants_drained", 64'(gr_q.size()), 64'd0);
    chk("rd_sb_drained", 64'(rd_q.size()), 64'd0);
    chk("wr_sb_drained", 64'(wr_q.size()), 64'd0);
    chk("b_idle_quiet", 64'({b_m_awready, b_m_wready, b_m_bvalid, b_s_awvalid, b_s_wvalid,
        b_s_bready, b_m_arready, b_m_rvalid, b_s_arvalid, b_s_rready, b_grant_oh}), 64'd0);
    chk("b_wr_bus", {b_s_awaddr, b_s_wdata}, 64'd0);
    chk("b_rdata_pass", {24'd0, b_s_wstrb, b_m_rdata}, {32'd0, 32'h5A5A_0001});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
